// File: rtl/ddr2_simple_host.sv
// Single-request DDR2 host: ACTIVATE, then one BL8 READ or WRITE, then PRECHARGE-all.
// Read beats are captured while the returning strobe pair is being driven by the memory.
module ddr2_simple_host #(
   parameter int TRCD       = 2,
   parameter int TRP        = 2,
   parameter int RD_TIMEOUT = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [12:0] req_row,
   input  logic [1:0]  req_bank,
   input  logic [9:0]  req_col,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   output logic [2:0]  rsp_beat,
   output logic [15:0] rsp_data,
   output logic        rsp_done,
   output logic        rsp_err,
   output logic        cke_pad,
   output logic        csbar_pad,
   output logic        rasbar_pad,
   output logic        casbar_pad,
   output logic        webar_pad,
   output logic [1:0]  ba_pad,
   output logic [12:0] a_pad,
   inout  wire  [15:0] dq_pad,
   inout  wire  [1:0]  dqs_pad,
   inout  wire  [1:0]  dqsbar_pad
);

   typedef enum logic [3:0] {
      IDLE, ACT, TRCD_WAIT, CMD, WR_DATA, RD_WAIT, RD_DATA, PRE, TRP_WAIT
   } state_t;

   localparam int CW = 16;

   // {csbar, rasbar, casbar, webar}
   localparam logic [3:0] CMD_DESEL = 4'b1111;
   localparam logic [3:0] CMD_NOP   = 4'b0111;
   localparam logic [3:0] CMD_ACT   = 4'b0011;
   localparam logic [3:0] CMD_WRITE = 4'b0100;
   localparam logic [3:0] CMD_READ  = 4'b0101;
   localparam logic [3:0] CMD_PRE   = 4'b0010;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      beat_q, beat_d;
   logic            cap_d, err_d;

   logic            wr_q;
   logic [12:0]     row_q;
   logic [1:0]      bank_q;
   logic [9:0]      col_q;
   logic [15:0]     wdata_q;

   logic            cke_q;
   logic [3:0]      cmd_q;
   logic [1:0]      ba_q;
   logic [12:0]     a_q;
   logic            oe_q;
   logic [1:0]      dqs_q;

   logic            rsp_valid_q, rsp_done_q, rsp_err_q;
   logic [2:0]      rsp_beat_q;
   logic [15:0]     rsp_data_q;

   logic            hs;
   logic            strobe_live;

   assign req_ready = (state_q == IDLE) && cke_q && !reset;
   assign hs        = req_valid && req_ready;

   // A driven strobe pair is always complementary; a released (pulled or floating)
   // pair is not, so this works for 2-state and 4-state views of the bus.
   assign strobe_live = &(dqs_pad ^ dqsbar_pad);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      beat_d  = beat_q;
      cap_d   = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (hs) state_d = ACT;
         end
         ACT: begin
            state_d = TRCD_WAIT;
            cnt_d   = CW'(TRCD - 1);
         end
         TRCD_WAIT: begin
            if (cnt_q == '0) state_d = CMD;
            else             cnt_d   = cnt_q - CW'(1);
         end
         CMD: begin
            beat_d = 3'd0;
            if (wr_q) begin
               state_d = WR_DATA;
            end else begin
               // READ cycle plus RD_TIMEOUT-1 wait cycles before giving up
               state_d = RD_WAIT;
               cnt_d   = CW'(RD_TIMEOUT - 2);
            end
         end
         WR_DATA: begin
            beat_d = beat_q + 3'd1;
            if (beat_q == 3'd7) state_d = PRE;
         end
         RD_WAIT: begin
            if (strobe_live) begin
               cap_d   = 1'b1;
               beat_d  = 3'd1;
               state_d = RD_DATA;
            end else if (cnt_q == '0) begin
               err_d   = 1'b1;
               state_d = PRE;
            end else begin
               cnt_d   = cnt_q - CW'(1);
            end
         end
         RD_DATA: begin
            if (!strobe_live) begin
               err_d   = 1'b1;
               state_d = PRE;
            end else begin
               cap_d  = 1'b1;
               beat_d = beat_q + 3'd1;
               if (beat_q == 3'd7) state_d = PRE;
            end
         end
         PRE: begin
            state_d = TRP_WAIT;
            cnt_d   = CW'(TRP - 1);
         end
         TRP_WAIT: begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - CW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   // Pad and response registers are loaded from the next state so each command
   // appears on the pins for exactly the cycle its state is active.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         beat_q      <= '0;
         wr_q        <= 1'b0;
         row_q       <= '0;
         bank_q      <= '0;
         col_q       <= '0;
         wdata_q     <= '0;
         cke_q       <= 1'b0;
         cmd_q       <= CMD_DESEL;
         ba_q        <= '0;
         a_q         <= '0;
         oe_q        <= 1'b0;
         dqs_q       <= 2'b00;
         rsp_valid_q <= 1'b0;
         rsp_beat_q  <= '0;
         rsp_data_q  <= '0;
         rsp_done_q  <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         beat_q  <= beat_d;
         cke_q   <= 1'b1;

         if (hs) begin
            wr_q    <= req_write;
            row_q   <= req_row;
            bank_q  <= req_bank;
            col_q   <= req_col;
            wdata_q <= req_wdata;
         end

         cmd_q <= CMD_NOP;
         ba_q  <= '0;
         a_q   <= '0;
         case (state_d)
            IDLE: cmd_q <= CMD_DESEL;
            ACT: begin
               cmd_q <= CMD_ACT;
               ba_q  <= req_bank;
               a_q   <= req_row;
            end
            TRCD_WAIT: begin
               ba_q <= bank_q;
               a_q  <= row_q;
            end
            CMD: begin
               cmd_q <= wr_q ? CMD_WRITE : CMD_READ;
               ba_q  <= bank_q;
               a_q   <= {3'b000, col_q};
            end
            PRE: begin
               cmd_q <= CMD_PRE;
               a_q   <= 13'h0400;
            end
            default: ;
         endcase

         oe_q  <= (state_d == WR_DATA);
         dqs_q <= (state_q == WR_DATA) ? ~dqs_q : 2'b00;

         rsp_valid_q <= cap_d;
         if (cap_d) begin
            rsp_beat_q <= beat_q;
            rsp_data_q <= dq_pad;
         end
         rsp_done_q <= (state_d == PRE);
         rsp_err_q  <= err_d;
      end
   end

   assign cke_pad    = cke_q;
   assign {csbar_pad, rasbar_pad, casbar_pad, webar_pad} = cmd_q;
   assign ba_pad     = ba_q;
   assign a_pad      = a_q;

   assign dq_pad     = oe_q ? wdata_q : 16'hzzzz;
   assign dqs_pad    = oe_q ? dqs_q   : 2'bzz;
   assign dqsbar_pad = oe_q ? ~dqs_q  : 2'bzz;

   assign rsp_valid  = rsp_valid_q;
   assign rsp_beat   = rsp_beat_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_done   = rsp_done_q;
   assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_ddr2_simple_host.sv
// Directed bench for ddr2_simple_host: write/read bursts, read timeout, strobe loss,
// back-to-back requests, reset mid-burst, and a second instance with TRCD=5/TRP=1.
module tb_ddr2_simple_host;

   localparam int READ_LAT = 10;
   localparam logic [3:0] C_DESEL = 4'b1111;
   localparam logic [3:0] C_NOP   = 4'b0111;
   localparam logic [3:0] C_ACT   = 4'b0011;
   localparam logic [3:0] C_WR    = 4'b0100;
   localparam logic [3:0] C_RD    = 4'b0101;
   localparam logic [3:0] C_PRE   = 4'b0010;

   logic clk = 1'b0;
   logic reset;
   logic req_valid, req_valid2, req_write;
   logic [12:0] req_row;
   logic [1:0]  req_bank;
   logic [9:0]  req_col;
   logic [15:0] req_wdata;

   logic req_ready, rsp_valid, rsp_done, rsp_err;
   logic [2:0] rsp_beat;
   logic [15:0] rsp_data;
   logic cke, csb, rasb, casb, web;
   logic [1:0] ba;
   logic [12:0] a;
   logic [3:0] cmd;
   tri1 [15:0] dq;
   tri1 [1:0]  dqs, dqsb;

   logic req_ready2, rsp_valid2, rsp_done2, rsp_err2;
   logic [2:0] rsp_beat2;
   logic [15:0] rsp_data2;
   logic cke2, csb2, rasb2, casb2, web2;
   logic [1:0] ba2;
   logic [12:0] a2;
   logic [3:0] cmd2;
   tri1 [15:0] dq2;
   tri1 [1:0]  dqs2, dqsb2;

   logic        m_oe = 1'b0;
   logic [15:0] m_dq = 16'h0000;
   logic [1:0]  m_dqs = 2'b00;
   logic        mem_en;
   int          drop_at;
   logic [15:0] mem [logic [24:0]];
   logic [12:0] open_row = '0;
   logic [24:0] mkey;

   int n_assert = 0, n_fail = 0;
   int n_valid = 0, n_done = 0, n_err = 0;
   int d0, e0, v0, nops, ovl;

   assign cmd  = {csb, rasb, casb, web};
   assign cmd2 = {csb2, rasb2, casb2, web2};
   assign dq   = m_oe ? m_dq : 16'hzzzz;
   assign dqs  = m_oe ? m_dqs : 2'bzz;
   assign dqsb = m_oe ? ~m_dqs : 2'bzz;

   always #5 clk = ~clk;

   ddr2_simple_host dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_row(req_row), .req_bank(req_bank), .req_col(req_col),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_beat(rsp_beat), .rsp_data(rsp_data),
      .rsp_done(rsp_done), .rsp_err(rsp_err), .cke_pad(cke), .csbar_pad(csb),
      .rasbar_pad(rasb), .casbar_pad(casb), .webar_pad(web), .ba_pad(ba), .a_pad(a),
      .dq_pad(dq), .dqs_pad(dqs), .dqsbar_pad(dqsb)
   );

   ddr2_simple_host #(.TRCD(5), .TRP(1)) dut2 (
      .clk(clk), .reset(reset), .req_valid(req_valid2), .req_ready(req_ready2),
      .req_write(req_write), .req_row(req_row), .req_bank(req_bank), .req_col(req_col),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid2), .rsp_beat(rsp_beat2), .rsp_data(rsp_data2),
      .rsp_done(rsp_done2), .rsp_err(rsp_err2), .cke_pad(cke2), .csbar_pad(csb2),
      .rasbar_pad(rasb2), .casbar_pad(casb2), .webar_pad(web2), .ba_pad(ba2), .a_pad(a2),
      .dq_pad(dq2), .dqs_pad(dqs2), .dqsbar_pad(dqsb2)
   );

   // Memory model: stores write bursts, answers READ after READ_LAT cycles,
   // optionally releasing the bus after drop_at beats.
   always begin
      @(posedge clk);
      if (cmd == C_ACT) begin
         open_row = a;
      end else if (cmd == C_WR) begin
         mkey = {ba, open_row, a[9:0]};
         for (int b = 0; b < 8; b++) begin
            @(posedge clk);
            mem[mkey] = dq;
         end
      end else if (cmd == C_RD && mem_en) begin
         mkey = {ba, open_row, a[9:0]};
         for (int i = 1; i < READ_LAT; i++) @(posedge clk);
         for (int b = 0; b < 8; b++) begin
            #1;
            m_oe  = (b < drop_at);
            m_dq  = mem.exists(mkey) ? mem[mkey] : 16'hDEAD;
            m_dqs = b[0] ? 2'b11 : 2'b00;
            @(posedge clk);
         end
         #1 m_oe = 1'b0;
      end
   end

   always @(posedge clk) begin
      if (rsp_valid === 1'b1) n_valid++;
      if (rsp_done === 1'b1)  n_done++;
      if (rsp_err === 1'b1)   n_err++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_valid2 = 1'b0; req_write = 1'b0;
      req_row = '0; req_bank = '0; req_col = '0; req_wdata = '0;
      mem_en = 1'b1; drop_at = 8;
      repeat (3) tick();
      chk("rst_cke", cke, 0);
      chk("rst_cmd", cmd, C_DESEL);
      chk("rst_ba_a", {ba, a}, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp", {rsp_valid, rsp_done, rsp_err, rsp_beat, rsp_data}, 0);
      chk("rst_dq_hiz", dq, 16'hFFFF);
      chk("rst_dqs_hiz", {dqs, dqsb}, 4'hF);
      reset = 1'b0;
      #1 chk("ready_before_edge", req_ready, 0);
      tick();
      chk("cke_up", cke, 1);
      chk("ready_up", req_ready, 1);
      chk("idle_cmd", cmd, C_DESEL);

      // write row 5 bank 2 col 8
      req_valid = 1'b1; req_write = 1'b1; req_row = 13'd5; req_bank = 2'd2;
      req_col = 10'd8; req_wdata = 16'hA5C3;
      d0 = n_done;
      tick();
      chk("wr_act", cmd, C_ACT);
      chk("wr_act_addr", {ba, a}, {2'd2, 13'd5});
      chk("wr_act_ready", req_ready, 0);
      req_valid = 1'b0;
      tick(); chk("wr_nop1", cmd, C_NOP);
      tick(); chk("wr_nop2", cmd, C_NOP);
      tick();
      chk("wr_cmd", cmd, C_WR);
      chk("wr_cmd_addr", {ba, a}, {2'd2, 13'd8});
      chk("wr_cmd_hiz", dq, 16'hFFFF);
      for (int b = 0; b < 8; b++) begin
         tick();
         chk("wr_dq", dq, 16'hA5C3);
         chk("wr_dqs", {dqs, dqsb}, b[0] ? 4'b1100 : 4'b0011);
         chk("wr_data_nop", cmd, C_NOP);
      end
      tick();
      chk("wr_pre", cmd, C_PRE);
      chk("wr_pre_addr", {ba, a}, {2'd0, 13'h0400});
      chk("wr_done", rsp_done, 1);
      chk("wr_released", dq, 16'hFFFF);
      tick(); chk("wr_trp1", cmd, C_NOP); chk("wr_done_pulse", rsp_done, 0);
      tick(); chk("wr_trp2", cmd, C_NOP);
      tick();
      chk("wr_idle", cmd, C_DESEL);
      chk("wr_idle_ready", req_ready, 1);
      chk("wr_done_count", n_done - d0, 1);

      // read back with the memory model
      req_valid = 1'b1; req_write = 1'b0;
      d0 = n_done; e0 = n_err; v0 = n_valid;
      tick(); chk("rd_act", cmd, C_ACT);
      req_valid = 1'b0;
      repeat (3) tick();
      chk("rd_cmd", cmd, C_RD);
      chk("rd_cmd_addr", {ba, a}, {2'd2, 13'd8});
      repeat (10) tick();
      chk("rd_no_early_beat", (n_valid - v0) + int'(rsp_valid), 0);
      for (int b = 0; b < 8; b++) begin
         tick();
         chk("rd_valid", rsp_valid, 1);
         chk("rd_beat", rsp_beat, b);
         chk("rd_data", rsp_data, 16'hA5C3);
      end
      chk("rd_pre_with_last", cmd, C_PRE);
      chk("rd_done", rsp_done, 1);
      repeat (3) tick();
      chk("rd_idle_ready", req_ready, 1);
      chk("rd_valid_count", n_valid - v0, 8);
      chk("rd_done_count", n_done - d0, 1);
      chk("rd_err_count", n_err - e0, 0);

      // read timeout: nobody drives the strobes
      mem_en = 1'b0;
      req_valid = 1'b1; req_bank = 2'd1; req_row = 13'd7; req_col = 10'd3;
      d0 = n_done; e0 = n_err; v0 = n_valid;
      tick(); req_valid = 1'b0;
      repeat (3) tick();
      chk("to_cmd", cmd, C_RD);
      repeat (31) tick();
      chk("to_not_yet", rsp_err, 0);
      chk("to_wait_nop", cmd, C_NOP);
      tick();
      chk("to_err", rsp_err, 1);
      chk("to_done", rsp_done, 1);
      chk("to_pre", cmd, C_PRE);
      tick(); chk("to_err_pulse", rsp_err, 0);
      repeat (2) tick();
      chk("to_idle_ready", req_ready, 1);
      chk("to_no_valid", n_valid - v0, 0);
      chk("to_err_count", n_err - e0, 1);
      chk("to_done_count", n_done - d0, 1);

      // strobe released after 4 beats
      mem_en = 1'b1; drop_at = 4;
      req_valid = 1'b1; req_bank = 2'd2; req_row = 13'd5; req_col = 10'd8;
      d0 = n_done; e0 = n_err; v0 = n_valid;
      tick(); req_valid = 1'b0;
      repeat (3) tick();
      chk("drop_cmd", cmd, C_RD);
      repeat (10) tick();
      for (int b = 0; b < 4; b++) begin
         tick();
         chk("drop_beat", {rsp_valid, rsp_beat}, {1'b1, 3'(b)});
      end
      tick();
      chk("drop_err", rsp_err, 1);
      chk("drop_no_valid", rsp_valid, 0);
      chk("drop_done", rsp_done, 1);
      chk("drop_pre", cmd, C_PRE);
      repeat (3) tick();
      chk("drop_idle_ready", req_ready, 1);
      chk("drop_valid_count", n_valid - v0, 4);
      chk("drop_err_count", n_err - e0, 1);
      drop_at = 8;
      repeat (2) tick();

      // req_valid held across two write requests
      req_valid = 1'b1; req_write = 1'b1; req_bank = 2'd3; req_row = 13'd9;
      req_col = 10'd16; req_wdata = 16'h1234;
      tick(); chk("b2b_act1", cmd, C_ACT);
      ovl = 0;
      repeat (14) begin
         tick();
         if (req_ready || cmd == C_ACT || cmd == C_DESEL) ovl++;
      end
      chk("b2b_busy", ovl, 0);
      tick();
      chk("b2b_idle_ready", req_ready, 1);
      chk("b2b_idle_cmd", cmd, C_DESEL);
      tick(); chk("b2b_act2", cmd, C_ACT);
      req_valid = 1'b0;
      repeat (14) tick();
      tick(); chk("b2b_end_ready", req_ready, 1);

      // reset during write beat 3
      req_valid = 1'b1; req_bank = 2'd0; req_row = 13'd11; req_col = 10'd20;
      req_wdata = 16'h3C5A;
      tick(); req_valid = 1'b0;
      repeat (3) tick();
      chk("rw_cmd", cmd, C_WR);
      repeat (4) tick();
      chk("rw_beat3", dq, 16'h3C5A);
      d0 = n_done; e0 = n_err;
      reset = 1'b1;
      tick();
      chk("rw_dq_hiz", dq, 16'hFFFF);
      chk("rw_dqs_hiz", {dqs, dqsb}, 4'hF);
      chk("rw_cke", cke, 0);
      chk("rw_cmd_desel", cmd, C_DESEL);
      chk("rw_no_done", rsp_done, 0);
      tick();
      reset = 1'b0;
      tick();
      chk("rw_cke_up", cke, 1);
      chk("rw_ready_up", req_ready, 1);
      tick();
      chk("rw_no_pulses", (n_done - d0) + (n_err - e0), 0);

      // second instance: TRCD=5, TRP=1
      req_valid2 = 1'b1; req_write = 1'b1; req_bank = 2'd1; req_row = 13'd2;
      req_col = 10'd4; req_wdata = 16'h0F0F;
      tick(); chk("t2_act", cmd2, C_ACT);
      req_valid2 = 1'b0;
      tick();
      nops = 0;
      while (cmd2 == C_NOP && nops < 40) begin nops++; tick(); end
      chk("t2_trcd_nops", nops, 5);
      chk("t2_wr", cmd2, C_WR);
      repeat (8) tick();
      chk("t2_dq", dq2, 16'h0F0F);
      tick(); chk("t2_pre", cmd2, C_PRE);
      tick();
      nops = 0;
      while (cmd2 == C_NOP && nops < 40) begin nops++; tick(); end
      chk("t2_trp_nops", nops, 1);
      chk("t2_idle", cmd2, C_DESEL);
      chk("t2_ready", req_ready2, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
